// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-client round-robin read arbiter in front of
// the 16x4 registered lookup ROM.
//   AW_DEF / DW_DEF : default address / data widths
//   state_e         : sequencer states (IDLE=00, ISSUE=01, CAPT=10)
package rom_arb_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    CAPT  = 2'b10
  } state_e;

endpackage

// File: rtl/rom_rr_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   elig  in  2  eligible clients (bit i = client i)
//   last  in  1  client granted most recently
//   valid out 1  at least one client eligible
//   pick  out 1  chosen client index
module rr_pick2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |elig;
    // On contention the client that did not win last time goes next;
    // otherwise the single eligible client wins.
    if (elig == 2'b11) begin
      pick = ~last;
    end else begin
      pick = elig[1];
    end
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: two-requester round-robin read arbiter and sequencer for the
// registered lookup ROM (one-cycle read latency).
//   clk              rising-edge clock shared with the ROM
//   rst              asynchronous active-low reset
//   req0/addr0       client 0 level request and address
//   req1/addr1       client 1 level request and address
//   ack0/ack1        one-cycle pulse: rdata valid for that client
//   rdata            returned data, held until the next ack
//   busy             high while in ISSUE or CAPT
//   rom_en/rom_addr  drive the ROM en/address
//   rom_dout         ROM data output
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  state_e        state_q, state_d;
  logic          rom_en_q, rom_en_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;

  logic [1:0]    elig;
  logic          pick_valid;
  logic          pick;

  // A client being acked this cycle is not eligible; a request still held
  // after its ack cycle counts as a new request.
  assign elig = {req1 & ~ack1_q, req0 & ~ack0_q};

  rr_pick2 u_pick (
    .elig  (elig),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_comb begin
    state_d    = state_q;
    rom_en_d   = rom_en_q;
    rom_addr_d = rom_addr_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    rdata_d    = rdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          rom_addr_d = pick ? addr1 : addr0;
          rom_en_d   = 1'b1;
          gnt_d      = pick;
          last_d     = pick;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rom_en_d = 1'b0;
        state_d  = CAPT;
      end
      CAPT: begin
        rdata_d = rom_dout;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        rom_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d == ISSUE) || (state_d == CAPT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
module tb_rom_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0;
  logic [3:0] addr0 = '0;
  logic       req1 = 1'b0;
  logic [3:0] addr1 = '0;
  logic       ack0, ack1, busy, rom_en;
  logic [3:0] rdata, rom_addr;
  logic [3:0] rom_dout = '0;

  int tests = 0;
  int fails = 0;
  int consec = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  rom_rr_arbiter #(.AW(4), .DW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .addr0    (addr0),
    .req1     (req1),
    .addr1    (addr1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rdata    (rdata),
    .busy     (busy),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  // Registered ROM with mem[a] = 15 - a; its reset is tied low.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= 4'd15 - rom_addr;
  end

  // rom_en must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (rom_en && prev_en) consec = consec + 1;
    prev_en = rom_en;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // Single read of address 3
    req0 = 1'b1; addr0 = 4'd3;
    step();
    chk("t1_en", rom_en, 1);
    chk("t1_addr", rom_addr, 3);
    chk("t1_busy_issue", busy, 1);
    step();
    chk("t1_en_off", rom_en, 0);
    chk("t1_busy_capt", busy, 1);
    chk("t1_noack", ack0, 0);
    step();
    chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    chk("t1_rdata", rdata, 4'hC);
    chk("t1_busy_idle", busy, 0);
    req0 = 1'b0;
    step();
    chk("t1_ack0_pulse", ack0, 0);
    chk("t1_ack1_never", ack1, 0);
    chk("t1_rdata_hold", rdata, 4'hC);

    // Contention straight after reset: client 0 first
    rst = 1'b0;
    step();
    rst = 1'b1;
    req0 = 1'b1; addr0 = 4'd0;
    req1 = 1'b1; addr1 = 4'd15;
    step();
    chk("t2_addr0", rom_addr, 0);
    step();
    step();
    chk("t2_ack0", ack0, 1);
    chk("t2_ack1_lo", ack1, 0);
    chk("t2_rdata0", rdata, 4'hF);
    req0 = 1'b0;
    step();
    chk("t2_en1", rom_en, 1);
    chk("t2_addr1", rom_addr, 15);
    step();
    step();
    chk("t2_ack1", ack1, 1);
    chk("t2_ack0_lo", ack0, 0);
    chk("t2_rdata1", rdata, 4'h0);
    req1 = 1'b0;
    step();

    // Sustained contention: strict alternation starting with client 0
    req0 = 1'b1; addr0 = 4'd2;
    req1 = 1'b1; addr1 = 4'd9;
    for (int g = 0; g < 6; g++) begin
      step();
      step();
      step();
      chk("t3_ack0", ack0, (g % 2 == 0) ? 1 : 0);
      chk("t3_ack1", ack1, (g % 2 == 1) ? 1 : 0);
      chk("t3_rdata", rdata, (g % 2 == 0) ? 4'hD : 4'h6);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("t3_no_consec_en", consec, 0);

    // Late arrival of client 1 during client 0's CAPT
    req0 = 1'b1; addr0 = 4'd4;
    step();
    step();
    req1 = 1'b1; addr1 = 4'd5;
    step();
    chk("t4_ack0", ack0, 1);
    chk("t4_rdata0", rdata, 4'hB);
    req0 = 1'b0;
    step();
    chk("t4_en1", rom_en, 1);
    chk("t4_addr1", rom_addr, 5);
    step();
    step();
    chk("t4_ack1", ack1, 1);
    chk("t4_rdata1", rdata, 4'hA);
    req1 = 1'b0;
    step();

    // Reset asserted during ISSUE
    req0 = 1'b1; addr0 = 4'd6;
    step();
    chk("t5_en_issue", rom_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_en_rst", rom_en, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_ack_rst", {ack1, ack0}, 0);
    chk("t5_rdata_rst", rdata, 0);
    req0 = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    step();
    chk("t5_no_ack", {ack1, ack0}, 0);
    req1 = 1'b1; addr1 = 4'd7;
    step();
    step();
    step();
    chk("t5_ack1", ack1, 1);
    chk("t5_rdata", rdata, 4'h8);
    req1 = 1'b0;
    step();

    // Ack-cycle rule: req0 held through its ack cycle and beyond
    req0 = 1'b1; addr0 = 4'd1;
    step();
    step();
    step();
    chk("t6_ack0", ack0, 1);
    chk("t6_rdata", rdata, 4'hE);
    step();
    chk("t6_no_dup_en", rom_en, 0);
    chk("t6_no_dup_busy", busy, 0);
    step();
    chk("t6_regrant_en", rom_en, 1);
    chk("t6_regrant_addr", rom_addr, 1);
    req0 = 1'b0;
    step();
    step();
    chk("t6_ack0_again", ack0, 1);
    chk("t6_rdata_again", rdata, 4'hE);
    step();
    chk("end_no_consec_en", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
